instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 119 +++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Encodes MIPS-style instruction fields into 32-bit words and streams them into instruction memory.
// Latency: one cycle from an accepted transfer to the imem write strobe; one transfer per cycle.
// Backpressure: in_ready drops while memory is full or a flush is in progress; illegal ops are consumed without a write.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              flush,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_FULL   = 1'b1
    } state_t;

    // count value just before the transfer that fills the memory
    localparam logic [ADDR_W:0] LAST_FREE = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;

    logic                xfer;
    logic                legal;
    logic [31:0]         enc_word;

    assign full     = (state_q == ST_FULL);
    assign in_ready = !full && !flush;
    assign xfer     = in_valid && in_ready;
    assign legal    = (op_sel <= 3'd5);

    // Field packing per opcode; fields unused by an op never reach the word.
    always_comb begin
        enc_word = 32'd0;
        case (op_sel)
            3'd0:    enc_word = {6'b000000, rs, rt, rd, shamt, funct};
            3'd1:    enc_word = {6'b100011, rs, rt, imm};
            3'd2:    enc_word = {6'b101011, rs, rt, imm};
            3'd3:    enc_word = {6'b000100, rs, rt, imm};
            3'd4:    enc_word = {6'b001000, rs, rt, imm};
            3'd5:    enc_word = {6'b000010, target};
            default: enc_word = 32'd0;
        endcase
    end

    // Next-state: flush dominates, then legal/illegal transfers; addr/wdata hold when not writing.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        if (flush) begin
            state_d = ST_ACCEPT;
            count_d = '0;
            err_d   = 1'b0;
        end else if (xfer) begin
            if (legal) begin
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_W-1:0];
                wdata_d = enc_word;
                count_d = count_q + ONE;
                if (count_q == LAST_FREE) begin
                    state_d = ST_FULL;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State and registered outputs; reset clears everything immediately, killing any pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ACCEPT;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign err        = err_q;

endmodule
